// File: rtl/btn_debounce_if.sv
// Button debouncer signal bundle: raw pin in, debounced level and event strobes out.
// slave = debouncer side, master = consumer/driver side.
interface btn_debounce_if;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_press
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_press
    );
endinterface

// File: rtl/btn_debounce.sv
// Synchronising push-button debouncer with press/release strobes and optional long-press strobe.
// Long-press detection is compiled in only when BTN_DEBOUNCE_LONG_PRESS_EN is defined.
module btn_debounce #(
    parameter int unsigned CLK_HZ      = 27000000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input logic           clk,
    input logic           rst,
    btn_debounce_if.slave bus
);

    localparam int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned DW              = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] D_LAST        = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (CLK_HZ / 1000 * LONG_MS <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("btn_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state, state_next;
    logic [DW-1:0] dcnt, dcnt_next;
    logic          s_in, s_meta, s;
    logic          held;
    logic          level_q, press_q, release_q;

    assign s_in = bus.btn_raw ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
        end else begin
            s_meta <= s_in;
            s      <= s_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RELEASED;
            dcnt  <= '0;
        end else begin
            state <= state_next;
            dcnt  <= dcnt_next;
        end
    end

    // Counter clears on every state change and idles at zero in the stable states.
    always_comb begin
        state_next = state;
        dcnt_next  = '0;
        case (state)
            RELEASED: begin
                if (s) state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!s)                  state_next = RELEASED;
                else if (dcnt == D_LAST) state_next = PRESSED;
                else                     dcnt_next  = dcnt + 1'b1;
            end
            PRESSED: begin
                if (!s) state_next = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (s)                   state_next = PRESSED;
                else if (dcnt == D_LAST) state_next = RELEASED;
                else                     dcnt_next  = dcnt + 1'b1;
            end
            default: state_next = RELEASED;
        endcase
    end

    assign held = (state == PRESSED) || (state == RELEASE_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= held;
            press_q   <= held && !level_q;
            release_q <= !held && level_q;
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned LONG_CYCLES = CLK_HZ / 1000 * LONG_MS;
    localparam int unsigned LW          = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] L_LAST    = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] L_MAX     = LW'(LONG_CYCLES);

    logic [LW-1:0] lcnt;
    logic          long_hit, long_q;

    // long_hit marks the count reaching its limit; long_q adds the same one-register
    // lag btn_level has, so the strobe lands LONG_CYCLES after btn_level rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcnt     <= '0;
            long_hit <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            long_hit <= 1'b0;
            if (state == PRESS_WAIT && state_next == PRESSED) begin
                lcnt <= '0;
            end else if (held && lcnt != L_MAX) begin
                lcnt     <= lcnt + 1'b1;
                long_hit <= (lcnt == L_LAST);
            end
            long_q <= long_hit;
        end
    end

    assign bus.long_press = long_q;
`else
    assign bus.long_press = 1'b0;
`endif

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20, meaning required stable time in ms; DEBOUNCE_CYCLES = CLK_HZ/1000*DEBOUNCE_MS (≥2).
REQ-003 SHALL have parameter LONG_MS, default 1000, meaning long-press threshold in ms; LONG_CYCLES = CLK_HZ/1000*LONG_MS (> DEBOUNCE_CYCLES).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1, meaning raw button reads 0 when pressed.
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port btn_raw  input  1  raw, bouncing, asynchronous button pin.
REQ-008 SHALL have port btn_level  output  1  debounced state, 1 = pressed.
REQ-009 SHALL have port press_pulse  output  1  one-cycle strobe on debounced press.
REQ-010 SHALL have port release_pulse  output  1  one-cycle strobe on debounced release.
REQ-011 SHALL have port long_press  output  1  one-cycle strobe when a press is held LONG_CYCLES.

Function
REQ-012 SHALL normalize s_in = btn_raw XOR ACTIVE_LOW, then pass it through a 2-flop synchronizer; output s is the only value used downstream.
REQ-013 SHALL implement FSM states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 RELEASED: s=1 -> PRESS_WAIT with debounce counter cleared; else stay.
REQ-015 PRESS_WAIT: s=0 -> RELEASED, counter cleared; s=1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED; else counter+1.
REQ-016 PRESSED: s=0 -> RELEASE_WAIT, counter cleared; else stay.
REQ-017 RELEASE_WAIT: s=1 -> PRESSED, counter cleared; s=0 and counter = DEBOUNCE_CYCLES-1 -> RELEASED; else counter+1.
REQ-018 btn_level SHALL be registered and equal 1 exactly while FSM is in PRESSED or RELEASE_WAIT.
REQ-019 press_pulse SHALL be 1 for exactly the one cycle in which btn_level first reads 1 after PRESS_WAIT->PRESSED; release_pulse likewise on RELEASE_WAIT->RELEASED; never both in one cycle.
REQ-020 Latency: a clean raw edge held indefinitely SHALL change btn_level exactly DEBOUNCE_CYCLES+3 rising edges after the first edge sampling the new raw value.
REQ-021 Any bounce shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no change on btn_level and no pulses.
REQ-022 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES) bits; long counter width clog2(LONG_CYCLES+1); neither counter shall wrap.
REQ-023 Long counter SHALL clear on entering PRESSED from PRESS_WAIT, increment each cycle in PRESSED or RELEASE_WAIT, saturate at LONG_CYCLES; long_press pulses once on the cycle the count reaches LONG_CYCLES.
REQ-024 long_press SHALL fire at most once per press; it re-arms only after a transition to RELEASED; a RELEASE_WAIT->PRESSED bounce SHALL NOT clear the long counter.

Reset
REQ-025 rst=1 SHALL asynchronously force FSM to RELEASED, synchronizer flops to 0 (released), both counters to 0, btn_level, press_pulse, release_pulse, long_press to 0.
REQ-026 Reset asserted mid-press SHALL emit no release_pulse; after release of rst a still-held button SHALL be re-qualified via PRESS_WAIT and produce a fresh press_pulse.

Configuration
REQ-027 Macro BTN_DEBOUNCE_LONG_PRESS_EN SHALL, when defined, compile in the long counter and REQ-023/024 behaviour.
REQ-028 Without BTN_DEBOUNCE_LONG_PRESS_EN, port long_press SHALL remain present and be tied to constant 0, with no long counter logic and LONG_MS unused.

Verification (CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=10, ACTIVE_LOW=1)
REQ-029 btn_raw 1->0 at edge 0, held -> btn_level 1 and press_pulse 1 at edge 7 only; press_pulse 0 at edge 8.
REQ-030 btn_raw pulses low 3 cycles then high, repeated 5 times -> btn_level stays 0, no pulses.
REQ-031 Press held 20 cycles past btn_level rise -> long_press single 1-cycle pulse 10 cycles after btn_level rise; release -> release_pulse 7 edges after raw rises.
REQ-032 During PRESSED, btn_raw high for 2 cycles then low -> btn_level stays 1, no release_pulse, long_press timing unchanged.
REQ-033 rst asserted asynchronously while pressed -> all outputs 0 before next edge; rst released with button held -> press_pulse 7 edges after first post-reset edge.
REQ-034 Build without BTN_DEBOUNCE_LONG_PRESS_EN, press held 50 cycles -> long_press constantly 0, press/release behaviour identical to REQ-029.
